// File: rtl/sha256_job_arbiter_if.sv
// Requester-side and core-side signals of the SHA-256 job arbiter, bundled so the arbiter
// (slave) and the requester/core environment (master) connect through one port.
interface sha256_job_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    req_valid;
    logic [32*NUM_REQ-1:0] req_num;
    logic [NUM_REQ-1:0]    req_grant;
    logic                  resp_valid;
    logic [ID_W-1:0]       resp_id;
    logic [255:0]          resp_digest;
    logic                  resp_err;
    logic                  busy;
    logic                  core_en;
    logic [31:0]           core_num;
    logic                  core_rdy;
    logic [255:0]          core_digest;

    modport slave (
        input  req_valid, req_num, core_rdy, core_digest,
        output req_grant, resp_valid, resp_id, resp_digest, resp_err, busy, core_en, core_num
    );

    modport master (
        output req_valid, req_num, core_rdy, core_digest,
        input  req_grant, resp_valid, resp_id, resp_digest, resp_err, busy, core_en, core_num
    );
endinterface

// File: rtl/sha256_job_arbiter.sv
// Round-robin front end sharing one sha256_top core among NUM_REQ requesters; watchdogs
// convert a hung core into an error response instead of a deadlock.
module sha256_job_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ACK_TIMEOUT = 16,
    parameter int RUN_TIMEOUT = 65536
) (
    input  logic                clk,
    input  logic                rst_n,
    sha256_job_arbiter_if.slave bus
);
    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int WD_MAX = (RUN_TIMEOUT > ACK_TIMEOUT) ? RUN_TIMEOUT : ACK_TIMEOUT;
    localparam int WD_W   = $clog2(WD_MAX + 1);
    localparam logic [WD_W-1:0] ACK_LIMIT = WD_W'(ACK_TIMEOUT - 1);
    localparam logic [WD_W-1:0] RUN_LIMIT = WD_W'(RUN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ACK,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [WD_W-1:0]    r_wdog;
    logic [WD_W-1:0]    w_wdogNext;
    logic [ID_W-1:0]    r_rrPtr;
    logic [ID_W-1:0]    w_rrPtrNext;
    logic [ID_W-1:0]    r_id;
    logic [ID_W-1:0]    w_idNext;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] w_grantNext;
    logic               r_respValid;
    logic               w_respValidNext;
    logic [ID_W-1:0]    r_respId;
    logic [ID_W-1:0]    w_respIdNext;
    logic [255:0]       r_respDigest;
    logic [255:0]       w_respDigestNext;
    logic               r_respErr;
    logic               w_respErrNext;
    logic               r_busy;
    logic               r_coreEn;
    logic [31:0]        r_coreNum;
    logic [31:0]        w_coreNumNext;

    logic               w_winValid;
    logic [ID_W-1:0]    w_winId;
    logic [31:0]        w_winNum;

    // Scan from the farthest offset down so the nearest valid requester after the pointer wins.
    always_comb begin : arbitrate
        int idx;
        idx        = 0;
        w_winValid = 1'b0;
        w_winId    = '0;
        w_winNum   = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = (int'(r_rrPtr) + off) % NUM_REQ;
            if (bus.req_valid[idx]) begin
                w_winValid = 1'b1;
                w_winId    = ID_W'(idx);
                w_winNum   = bus.req_num[32*idx +: 32];
            end
        end
    end

    always_comb begin
        w_nextState      = r_state;
        w_wdogNext       = r_wdog;
        w_rrPtrNext      = r_rrPtr;
        w_idNext         = r_id;
        w_grantNext      = '0;
        w_respValidNext  = 1'b0;
        w_respIdNext     = r_respId;
        w_respDigestNext = r_respDigest;
        w_respErrNext    = r_respErr;
        w_coreNumNext    = r_coreNum;

        case (r_state)
            S_IDLE: begin
                if (bus.core_rdy && w_winValid) begin
                    w_nextState   = S_START;
                    w_idNext      = w_winId;
                    w_coreNumNext = w_winNum;
                    w_grantNext   = NUM_REQ'(1) << w_winId;
                end
            end
            S_START: begin
                w_nextState = S_ACK;
                w_wdogNext  = '0;
            end
            S_ACK: begin
                if (!bus.core_rdy) begin
                    w_nextState = S_RUN;
                    w_wdogNext  = '0;
                end else if (r_wdog >= ACK_LIMIT) begin
                    w_nextState      = S_DONE;
                    w_respValidNext  = 1'b1;
                    w_respIdNext     = r_id;
                    w_respDigestNext = '0;
                    w_respErrNext    = 1'b1;
                end else if (r_wdog != '1) begin
                    w_wdogNext = r_wdog + 1'b1;
                end
            end
            S_RUN: begin
                if (bus.core_rdy) begin
                    w_nextState      = S_DONE;
                    w_respValidNext  = 1'b1;
                    w_respIdNext     = r_id;
                    w_respDigestNext = bus.core_digest;
                    w_respErrNext    = 1'b0;
                end else if (r_wdog >= RUN_LIMIT) begin
                    w_nextState      = S_DONE;
                    w_respValidNext  = 1'b1;
                    w_respIdNext     = r_id;
                    w_respDigestNext = '0;
                    w_respErrNext    = 1'b1;
                end else if (r_wdog != '1) begin
                    w_wdogNext = r_wdog + 1'b1;
                end
            end
            S_DONE: begin
                w_nextState = S_IDLE;
                w_rrPtrNext = r_id;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // core_en follows START by one cycle so it lands the cycle after the grant pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_wdog       <= '0;
            r_rrPtr      <= ID_W'(NUM_REQ - 1);
            r_id         <= '0;
            r_grant      <= '0;
            r_respValid  <= 1'b0;
            r_respId     <= '0;
            r_respDigest <= '0;
            r_respErr    <= 1'b0;
            r_busy       <= 1'b0;
            r_coreEn     <= 1'b0;
            r_coreNum    <= '0;
        end else begin
            r_state      <= w_nextState;
            r_wdog       <= w_wdogNext;
            r_rrPtr      <= w_rrPtrNext;
            r_id         <= w_idNext;
            r_grant      <= w_grantNext;
            r_respValid  <= w_respValidNext;
            r_respId     <= w_respIdNext;
            r_respDigest <= w_respDigestNext;
            r_respErr    <= w_respErrNext;
            r_busy       <= (w_nextState != S_IDLE);
            r_coreEn     <= (r_state == S_START);
            r_coreNum    <= w_coreNumNext;
        end
    end

    assign bus.req_grant   = r_grant;
    assign bus.resp_valid  = r_respValid;
    assign bus.resp_id     = r_respId;
    assign bus.resp_digest = r_respDigest;
    assign bus.resp_err    = r_respErr;
    assign bus.busy        = r_busy;
    assign bus.core_en     = r_coreEn;
    assign bus.core_num    = r_coreNum;
endmodule
